plot_sink: RTL and testbench

PLOT_SINK -- requirements
Module: plot_sink

---
 rtl/plot_sink.sv | 108 ++++++++++
 tb/tb_plot_sink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
// Pixel plot sink: a 4-deep write queue in front of a 160x120x3 framebuffer.
// Scan-out reads have strict priority over queued writes on the single memory port.
module plot_sink (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        plot_valid,
    output logic        plot_ready,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  color,
    input  logic        scan_en,
    input  logic [7:0]  scan_x,
    input  logic [6:0]  scan_y,
    output logic [2:0]  scan_color,
    output logic        scan_valid,
    output logic [7:0]  drop_count,
    output logic [14:0] pix_count
);

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  color;
    } pix_t;

    pix_t        fifo [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  fb [SCR_W*SCR_H];

    logic        plot_in_range;
    logic        scan_in_range;
    logic [14:0] plot_addr;
    logic [14:0] scan_addr;
    logic        accept;
    logic        push;
    logic        pop;
    pix_t        head;

    // y*160 + x without a multiplier
    assign plot_addr     = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    assign scan_addr     = ({8'd0, scan_y} << 7) + ({8'd0, scan_y} << 5) + {7'd0, scan_x};
    assign plot_in_range = (x < 8'(SCR_W)) && (y < 7'(SCR_H));
    assign scan_in_range = (scan_x < 8'(SCR_W)) && (scan_y < 7'(SCR_H));

    assign plot_ready = (count != 3'(DEPTH));
    assign accept     = plot_valid && plot_ready;
    assign push       = accept && plot_in_range;
    assign pop        = !scan_en && (count != 3'd0);
    assign head       = fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{addr: plot_addr, color: color};
    end

    // Framebuffer is deliberately outside reset: contents survive reset_n.
    always_ff @(posedge clk) begin
        if (pop)
            fb[head.addr] <= head.color;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_valid <= 1'b0;
            scan_color <= '0;
        end else begin
            scan_valid <= scan_en;
            if (scan_en)
                scan_color <= scan_in_range ? fb[scan_addr] : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
            pix_count  <= '0;
        end else begin
            if (accept && !plot_in_range && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            if (pop && pix_count != 15'h7FFF)
                pix_count <= pix_count + 15'd1;
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Scoreboard bench for plot_sink: scan expectations queued at the scan edge, checked on scan_valid.
`timescale 1ns/1ps
module tb_plot_sink;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        plot_valid;
    logic        plot_ready;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        scan_en;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_color;
    logic        scan_valid;
    logic [7:0]  drop_count;
    logic [14:0] pix_count;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] model [0:19199];
    logic [2:0] sb [$];

    plot_sink dut (
        .clk(clk), .reset_n(reset_n),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .x(x), .y(y), .color(color),
        .scan_en(scan_en), .scan_x(scan_x), .scan_y(scan_y),
        .scan_color(scan_color), .scan_valid(scan_valid),
        .drop_count(drop_count), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_rd(input logic [7:0] sx, input logic [6:0] sy);
        if (sx >= 8'd160 || sy >= 7'd120)
            return 3'd0;
        return model[int'(sy) * 160 + int'(sx)];
    endfunction

    // A scan sampled at an edge must show up on scan_valid in the following cycle.
    always @(posedge clk)
        if (reset_n && scan_en)
            sb.push_back(model_rd(scan_x, scan_y));

    always @(negedge clk) begin
        logic [2:0] exp_c;
        if (reset_n && (scan_valid || sb.size() != 0)) begin
            chk("scan_valid", 32'(scan_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                exp_c = sb.pop_front();
                chk("scan_color", 32'(scan_color), 32'(exp_c));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One accepted plot followed by an idle cycle so it drains (scan_en must be low).
    task automatic plot1(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        int t = 0;
        plot_valid = 1'b1; x = px; y = py; color = pc;
        while (!plot_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("plot_ready_timeout", 32'(plot_ready), 32'd1);
        tick();
        plot_valid = 1'b0;
        tick();
        if (px < 8'd160 && py < 7'd120)
            model[int'(py) * 160 + int'(px)] = pc;
    endtask

    task automatic scan1(input logic [7:0] sx, input logic [6:0] sy);
        scan_en = 1'b1; scan_x = sx; scan_y = sy;
        tick();
        scan_en = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [14:0] pix0;

        reset_n = 1'b0; plot_valid = 1'b0; x = '0; y = '0; color = '0;
        scan_en = 1'b0; scan_x = '0; scan_y = '0;
        tick(); tick();
        chk("rst_ready", 32'(plot_ready), 32'd1);
        chk("rst_svalid", 32'(scan_valid), 32'd0);
        chk("rst_scolor", 32'(scan_color), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_pix", 32'(pix_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // single plot then read back
        plot1(8'd5, 7'd2, 3'd3);
        chk("pix_after_1", 32'(pix_count), 32'd1);
        scan1(8'd5, 7'd2);

        // FIFO fills under continuous scan, then drains in 4 cycles
        scan_en = 1'b1; scan_x = 8'd160; scan_y = 7'd0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            plot_valid = 1'b1; x = 8'(20 + i); y = 7'd3; color = 3'(i + 1);
            if (plot_ready) acc++;
            tick();
        end
        plot_valid = 1'b0;
        chk("stall_accepts", 32'(acc), 32'd4);
        chk("stall_ready", 32'(plot_ready), 32'd0);
        chk("stall_pix", 32'(pix_count), 32'd1);
        scan_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_pix", 32'(pix_count), 32'(1 + k));
        end
        chk("drain_ready", 32'(plot_ready), 32'd1);
        for (int i = 0; i < 4; i++) model[3 * 160 + 20 + i] = 3'(i + 1);
        for (int i = 0; i < 4; i++) scan1(8'(20 + i), 7'd3);

        // out-of-range plots are dropped
        pix0 = pix_count;
        plot1(8'd160, 7'd0, 3'd1);
        plot1(8'd0, 7'd120, 3'd1);
        chk("drop_2", 32'(drop_count), 32'd2);
        chk("drop_pix", 32'(pix_count), 32'(pix0));
        scan1(8'd160, 7'd0);

        // back-to-back writes to one address: later colour wins
        plot_valid = 1'b1; x = 8'd10; y = 7'd10; color = 3'd1;
        tick();
        color = 3'd6;
        tick();
        plot_valid = 1'b0;
        tick(); tick();
        model[10 * 160 + 10] = 3'd6;
        chk("b2b_pix", 32'(pix_count), 32'(pix0 + 15'd2));
        scan1(8'd10, 7'd10);
        tick();
        chk("scolor_hold", 32'(scan_color), 32'd6);

        // drop counter saturates
        plot_valid = 1'b1; x = 8'd200; y = 7'd0;
        repeat (260) tick();
        plot_valid = 1'b0;
        chk("drop_sat", 32'(drop_count), 32'd255);

        // reset with queued writes: they are lost, memory kept
        for (int i = 0; i < 3; i++) plot1(8'(30 + i), 7'd4, 3'd2);
        scan_en = 1'b1; scan_x = 8'd30; scan_y = 7'd4;
        for (int i = 0; i < 3; i++) begin
            plot_valid = 1'b1; x = 8'(30 + i); y = 7'd4; color = 3'd5;
            tick();
        end
        plot_valid = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        scan_en = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(plot_ready), 32'd1);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        chk("mid_rst_pix", 32'(pix_count), 32'd0);
        chk("mid_rst_svalid", 32'(scan_valid), 32'd0);
        chk("mid_rst_scolor", 32'(scan_color), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_pix", 32'(pix_count), 32'd0);
        for (int i = 0; i < 3; i++) scan1(8'(30 + i), 7'd4);

        // full-screen fill and scan
        plot_valid = 1'b1;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                x = 8'(xx); y = 7'(yy); color = 3'((xx + yy) % 8);
                model[yy * 160 + xx] = color;
                tick();
            end
        plot_valid = 1'b0;
        tick();
        chk("fill_pix", 32'(pix_count), 32'd19200);
        scan_en = 1'b1;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                scan_x = 8'(xx); scan_y = 7'(yy);
                tick();
            end
        scan_en = 1'b0;
        tick();
        scan1(8'd159, 7'd119);

        // pixel counter saturates
        plot_valid = 1'b1; x = 8'd0; y = 7'd0; color = 3'd0;
        repeat (32767 - 19200 + 10) tick();
        plot_valid = 1'b0;
        tick();
        chk("pix_sat", 32'(pix_count), 32'd32767);
        scan1(8'd0, 7'd0);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
